// File: rtl/param_bus_pkg.sv
// Shared types and default sizes for the parameter bus sequencer.
package param_bus_pkg;

    // Write sequencing phases: grant in IDLE, payload setup, strobe, hold.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    localparam int DEF_BANK_W     = 3;
    localparam int DEF_ADR_W      = 7;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_STROBE_CYC = 2;
    localparam int DEF_HOLD_CYC   = 4;

    // Larger of two integers, used to size the shared phase counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Requester arbiter: one-hot grant, encoded winner index and pointer update.
// Build option PARAM_BUS_FIXED_PRIO_EN: fixed priority (lowest index wins),
// no pointer. Default build: round-robin searching from pointer+1 with wrap.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             reg_clk,
    input  logic             reset_reg,
    input  logic [N-1:0]     req,
    input  logic             grant_en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

`ifdef PARAM_BUS_FIXED_PRIO_EN

    // The sequencer clock/reset/enable are not needed without a pointer.
    logic unused_ok;
    assign unused_ok = &{1'b0, reg_clk, reset_reg, grant_en};

    // Fixed priority: scan downwards so the lowest requesting index wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant       = '0;
                grant[i]    = 1'b1;
                grant_idx   = IDX_W'(i);
                grant_valid = 1'b1;
            end
        end
    end

`else

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Round-robin: first requester after the last winner, wrapping at N.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] jj;
        j           = 0;
        jj          = '0;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int off = 1; off <= N; off++) begin
            j = int'(ptr_q) + off;
            if (j >= N) begin
                j = j - N;
            end
            jj = IDX_W'(j);
            if (!grant_valid && req[jj]) begin
                grant[jj]   = 1'b1;
                grant_idx   = jj;
                grant_valid = 1'b1;
            end
        end
    end

    // Pointer follows the winner only when the sequencer takes the grant.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_en && grant_valid) begin
            ptr_d = grant_idx;
        end
    end

    // Pointer register; reset to N-1 so requester 0 is searched first.
    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            ptr_q <= IDX_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

`endif

endmodule

// File: rtl/param_bus_sequencer.sv
// Parameter bank write sequencer: arbitrates requesters and drives each
// granted write as setup, data_ready strobe, then hold, acking at the end.
// Build option PARAM_BUS_FIXED_PRIO_EN (in rr_arbiter) selects fixed priority.
module param_bus_sequencer
    import param_bus_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int BANK_W     = DEF_BANK_W,
    parameter int ADR_W      = DEF_ADR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      reg_clk,
    input  logic                      reset_reg,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*BANK_W-1:0] req_bank,
    input  logic [NUM_REQ*ADR_W-1:0]  req_adr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [SRC_W-1:0]          active_src,
    output logic                      data_ready,
    output logic [BANK_W-1:0]         bank_adr,
    output logic [ADR_W-1:0]          adr,
    output logic [DATA_W-1:0]         out_data
);

    localparam int CNT_W = $clog2(max2(STROBE_CYC, HOLD_CYC) + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                dr_q, dr_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [ADR_W-1:0]    adr_q, adr_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [NUM_REQ-1:0]  grant;
    logic [SRC_W-1:0]    grant_idx;
    logic                grant_valid;
    logic [BANK_W-1:0]   sel_bank;
    logic [ADR_W-1:0]    sel_adr;
    logic [DATA_W-1:0]   sel_data;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (SRC_W)
    ) u_arb (
        .reg_clk     (reg_clk),
        .reset_reg   (reset_reg),
        .req         (req),
        .grant_en    (state_q == ST_IDLE),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // AND-OR select of the granted requester's payload using the one-hot grant.
    always_comb begin
        sel_bank = '0;
        sel_adr  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_bank = sel_bank | req_bank[i*BANK_W +: BANK_W];
                sel_adr  = sel_adr  | req_adr[i*ADR_W +: ADR_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next state, phase counter, latched payload and registered output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        bank_d  = bank_q;
        adr_d   = adr_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_SETUP;
                    src_d   = grant_idx;
                    bank_d  = sel_bank;
                    adr_d   = sel_adr;
                    data_d  = sel_data;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = CNT_W'(STROBE_CYC - 1);
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        dr_d   = (state_d == ST_STROBE);
        ack_d  = '0;
        if (state_d == ST_HOLD && cnt_d == '0) begin
            ack_d[src_q] = 1'b1;
        end
    end

    // State and output registers; reset abandons any in-flight write.
    always_ff @(posedge reg_clk) begin
        if (reset_reg) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            dr_q    <= 1'b0;
            src_q   <= '0;
            bank_q  <= '0;
            adr_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            dr_q    <= dr_d;
            src_q   <= src_d;
            bank_q  <= bank_d;
            adr_q   <= adr_d;
            data_q  <= data_d;
        end
    end

    assign ack        = ack_q;
    assign busy       = busy_q;
    assign active_src = src_q;
    assign data_ready = dr_q;
    assign bank_adr   = bank_q;
    assign adr        = adr_q;
    assign out_data   = data_q;

endmodule
